// File: rtl/pc_target_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_target_sequencer
// Brief    : PC register, next-PC target generator and circular return-address
//            stack. Optional macro PC_ALIGN_CHECK_EN traps misaligned REG targets.
// Revision : 1.0 - initial release
// ============================================================================
module pc_target_sequencer #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     IMM_W     = 26,
    parameter int unsigned     OFF_W     = 16,
    parameter int unsigned     RAS_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_write,
    input  logic [2:0]       mode,
    input  logic [IMM_W-1:0] imm,
    input  logic [OFF_W-1:0] offset,
    input  logic [XLEN-1:0]  reg_target,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_underflow,
    output logic             misalign_err
);

    localparam int unsigned        c_PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned        c_CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(RAS_DEPTH);

    localparam logic [2:0] c_MODE_BRANCH = 3'd1;
    localparam logic [2:0] c_MODE_JUMP   = 3'd2;
    localparam logic [2:0] c_MODE_CALL   = 3'd3;
    localparam logic [2:0] c_MODE_RET    = 3'd4;
    localparam logic [2:0] c_MODE_REG    = 3'd5;

    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_ras [RAS_DEPTH];
    logic [c_PTR_W-1:0] r_top;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_underflow;
    logic               r_misalign;

    logic [XLEN-1:0]    w_pc_plus4;
    logic [XLEN-1:0]    w_branch_disp;
    logic [XLEN-1:0]    w_jump_target;
    logic [XLEN-1:0]    w_next_pc;
    logic [c_PTR_W-1:0] w_top_m1;
    logic               w_ras_empty;
    logic               w_ras_full;
    logic               w_push;
    logic               w_pop;
    logic               w_underflow;
    logic               w_misalign;
    logic               w_hold;

    assign w_pc_plus4    = r_pc + XLEN'(4);
    assign w_branch_disp = {{(XLEN-OFF_W-2){offset[OFF_W-1]}}, offset, 2'b00};
    assign w_jump_target = {w_pc_plus4[XLEN-1:IMM_W+2], imm, 2'b00};
    // r_top is the next write slot; the most recent entry sits one below it.
    assign w_top_m1      = r_top - c_PTR_W'(1);
    assign w_ras_empty   = (r_cnt == '0);
    assign w_ras_full    = (r_cnt == c_DEPTH);

`ifndef PC_ALIGN_CHECK_EN
    logic w_unused;
    assign w_unused = ^reg_target[1:0];
`endif

    always_comb begin
        w_next_pc   = w_pc_plus4;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_underflow = 1'b0;
        w_misalign  = 1'b0;
        w_hold      = 1'b0;
        case (mode)
            c_MODE_BRANCH: w_next_pc = w_pc_plus4 + w_branch_disp;
            c_MODE_JUMP:   w_next_pc = w_jump_target;
            c_MODE_CALL: begin
                w_next_pc = w_jump_target;
                w_push    = 1'b1;
            end
            c_MODE_RET: begin
                if (w_ras_empty) begin
                    w_underflow = 1'b1;
                end else begin
                    w_pop     = 1'b1;
                    w_next_pc = r_ras[w_top_m1];
                end
            end
            c_MODE_REG: begin
`ifdef PC_ALIGN_CHECK_EN
                if (reg_target[1:0] != 2'b00) begin
                    w_hold     = 1'b1;
                    w_misalign = 1'b1;
                end else begin
                    w_next_pc = reg_target;
                end
`else
                w_next_pc = {reg_target[XLEN-1:2], 2'b00};
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= RESET_PC;
            r_top       <= '0;
            r_cnt       <= '0;
            r_underflow <= 1'b0;
            r_misalign  <= 1'b0;
        end else begin
            r_underflow <= pc_write & w_underflow;
            r_misalign  <= pc_write & w_misalign;
            if (pc_write) begin
                if (!w_hold) begin
                    r_pc <= w_next_pc;
                end
                // A push into a full stack lands on the oldest slot; count saturates.
                if (w_push) begin
                    r_ras[r_top] <= w_pc_plus4;
                    r_top        <= r_top + c_PTR_W'(1);
                    if (!w_ras_full) begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                if (w_pop) begin
                    r_top <= w_top_m1;
                    r_cnt <= r_cnt - c_CNT_W'(1);
                end
            end
        end
    end

    assign pc            = r_pc;
    assign pc_plus4      = w_pc_plus4;
    assign ras_empty     = w_ras_empty;
    assign ras_full      = w_ras_full;
    assign ras_underflow = r_underflow;
    assign misalign_err  = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_pc_target_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_target_sequencer
// Brief    : Directed and randomized checks of pc_target_sequencer against a
//            queue-based reference model (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_target_sequencer;

    localparam int unsigned c_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pc_write = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic [25:0] imm = '0;
    logic [15:0] offset = '0;
    logic [31:0] reg_target = '0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_underflow;
    logic        misalign_err;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_pc = '0;
    logic [31:0] m_ras[$];
    logic        m_uf = 1'b0;
    logic        m_mis = 1'b0;

    pc_target_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .pc_write      (pc_write),
        .mode          (mode),
        .imm           (imm),
        .offset        (offset),
        .reg_target    (reg_target),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_underflow (ras_underflow),
        .misalign_err  (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic void model_commit(input logic rs, input logic pw, input logic [2:0] md,
                                         input logic [25:0] im, input logic [15:0] of,
                                         input logic [31:0] rt);
        logic [31:0] p4;
        m_uf  = 1'b0;
        m_mis = 1'b0;
        if (rs) begin
            m_pc = 32'h0;
            m_ras.delete();
            return;
        end
        if (!pw) return;
        p4 = m_pc + 32'd4;
        case (md)
            3'd1: m_pc = p4 + 32'($signed(of)) * 32'd4;
            3'd2: m_pc = {p4[31:28], im, 2'b00};
            3'd3: begin
                m_ras.push_back(p4);
                if (m_ras.size() > c_DEPTH) void'(m_ras.pop_front());
                m_pc = {p4[31:28], im, 2'b00};
            end
            3'd4: begin
                if (m_ras.size() == 0) begin
                    m_pc = p4;
                    m_uf = 1'b1;
                end else begin
                    m_pc = m_ras.pop_back();
                end
            end
            3'd5: begin
`ifdef PC_ALIGN_CHECK_EN
                if (rt[1:0] != 2'b00) m_mis = 1'b1;
                else m_pc = rt;
`else
                m_pc = rt & 32'hFFFF_FFFC;
`endif
            end
            default: m_pc = p4;
        endcase
    endfunction

    // Drives one cycle of inputs, advances the model, samples 1 ns after the edge.
    task automatic step(input logic rs, input logic pw, input logic [2:0] md,
                        input logic [25:0] im, input logic [15:0] of, input logic [31:0] rt);
        reset      = rs;
        pc_write   = pw;
        mode       = md;
        imm        = im;
        offset     = of;
        reg_target = rt;
        model_commit(rs, pw, md, im, of, rt);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 3'd0, '0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 3'($urandom_range(0, 7)), 26'($urandom), 16'($urandom), $urandom);
            total++;
            if (pc !== 32'h0 || ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_underflow !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold cycle %0d: pc=%h empty=%b full=%b uf=%b required pc=00000000 empty=1 full=0 uf=0",
                         i, pc, ras_empty, ras_full, ras_underflow);
            end
        end
        total++;
        if (pc_plus4 !== 32'h4) begin
            bad++;
            $display("FAIL reset_pc_plus4: got %h required 00000004", pc_plus4);
        end
    endtask

    task automatic test_branch();
        step(1'b0, 1'b1, 3'd5, '0, '0, 32'h0040_0000);
        step(1'b0, 1'b1, 3'd1, '0, 16'hFFFF, '0);
        total++;
        if (pc !== 32'h0040_0000) begin
            bad++;
            $display("FAIL branch_back: pc=%h required 00400000", pc);
        end
        step(1'b0, 1'b1, 3'd1, '0, 16'h0003, '0);
        total++;
        if (pc !== 32'h0040_0010) begin
            bad++;
            $display("FAIL branch_fwd: pc=%h required 00400010", pc);
        end
        // Wrap below zero
        step(1'b0, 1'b1, 3'd5, '0, '0, 32'h0000_0000);
        step(1'b0, 1'b1, 3'd1, '0, 16'hFFFD, '0);
        total++;
        if (pc !== 32'hFFFF_FFF8) begin
            bad++;
            $display("FAIL branch_wrap: pc=%h required fffffff8", pc);
        end
    endtask

    task automatic test_jump();
        step(1'b0, 1'b1, 3'd5, '0, '0, 32'hA000_0100);
        step(1'b0, 1'b1, 3'd2, 26'h0123456, '0, '0);
        total++;
        if (pc !== 32'hA048_D158 || ras_empty !== 1'b1) begin
            bad++;
            $display("FAIL jump: pc=%h empty=%b required a048d158 empty=1", pc, ras_empty);
        end
    endtask

    task automatic test_call_ret();
        logic [31:0] exp_ret [4];
        step(1'b1, 1'b0, 3'd0, '0, '0, '0);
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 1'b1, 3'd5, '0, '0, 32'(i) * 32'h100);
            step(1'b0, 1'b1, 3'd3, 26'h0000800, '0, '0);
        end
        total++;
        if (ras_full !== 1'b1 || ras_empty !== 1'b0 || pc !== 32'h0000_2000) begin
            bad++;
            $display("FAIL call_full: full=%b empty=%b pc=%h required full=1 empty=0 pc=00002000",
                     ras_full, ras_empty, pc);
        end
        exp_ret[0] = 32'h504;
        exp_ret[1] = 32'h404;
        exp_ret[2] = 32'h304;
        exp_ret[3] = 32'h204;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 3'd4, '0, '0, '0);
            total++;
            if (pc !== exp_ret[i] || ras_underflow !== 1'b0) begin
                bad++;
                $display("FAIL ret_%0d: pc=%h uf=%b required %h uf=0", i, pc, ras_underflow, exp_ret[i]);
            end
        end
        total++;
        if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin
            bad++;
            $display("FAIL ret_empty: empty=%b full=%b required empty=1 full=0", ras_empty, ras_full);
        end
        step(1'b0, 1'b1, 3'd4, '0, '0, '0);
        total++;
        if (pc !== 32'h208 || ras_underflow !== 1'b1) begin
            bad++;
            $display("FAIL ret_underflow: pc=%h uf=%b required 00000208 uf=1", pc, ras_underflow);
        end
        step(1'b0, 1'b0, 3'd4, '0, '0, '0);
        total++;
        if (pc !== 32'h208 || ras_underflow !== 1'b0) begin
            bad++;
            $display("FAIL underflow_pulse: pc=%h uf=%b required 00000208 uf=0", pc, ras_underflow);
        end
    endtask

    task automatic test_reset_priority();
        step(1'b0, 1'b1, 3'd5, '0, '0, 32'h0000_7000);
        step(1'b0, 1'b1, 3'd3, 26'h0000123, '0, '0);
        step(1'b1, 1'b1, 3'd3, 26'h0000456, '0, '0);
        total++;
        if (pc !== 32'h0 || ras_empty !== 1'b1) begin
            bad++;
            $display("FAIL reset_priority: pc=%h empty=%b required 00000000 empty=1", pc, ras_empty);
        end
    endtask

    task automatic test_reg();
        step(1'b0, 1'b1, 3'd5, '0, '0, 32'h0000_3000);
        step(1'b0, 1'b1, 3'd5, '0, '0, 32'h0000_1002);
`ifdef PC_ALIGN_CHECK_EN
        total++;
        if (pc !== 32'h0000_3000 || misalign_err !== 1'b1) begin
            bad++;
            $display("FAIL reg_misalign: pc=%h err=%b required 00003000 err=1", pc, misalign_err);
        end
`else
        total++;
        if (pc !== 32'h0000_1000 || misalign_err !== 1'b0) begin
            bad++;
            $display("FAIL reg_align: pc=%h err=%b required 00001000 err=0", pc, misalign_err);
        end
`endif
        step(1'b0, 1'b1, 3'd6, '0, '0, '0);
        total++;
        if (pc !== m_pc || misalign_err !== 1'b0) begin
            bad++;
            $display("FAIL mode6_seq: pc=%h err=%b required %h err=0", pc, misalign_err, m_pc);
        end
    endtask

    task automatic test_random();
        logic [67:0] got;
        logic [67:0] exp;
        logic        rs;
        logic        pw;
        for (int i = 0; i < 400; i++) begin
            rs = ($urandom_range(0, 49) == 0);
            pw = ($urandom_range(0, 3) != 0);
            step(rs, pw, 3'($urandom_range(0, 7)), 26'($urandom), 16'($urandom),
                 ($urandom_range(0, 1) == 1) ? ($urandom & 32'hFFFF_FFFC) : $urandom);
            got = {pc, pc_plus4, ras_empty, ras_full, ras_underflow, misalign_err};
            exp = {m_pc, m_pc + 32'd4, m_ras.size() == 0, m_ras.size() == c_DEPTH, m_uf, m_mis};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL random_%0d: {pc,pc4,empty,full,uf,mis}=%h required %h", i, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_jump();
        test_call_ret();
        test_reset_priority();
        test_reg();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
